alu_rr_sched: RTL and testbench



---
 rtl/alu_rr_sched.sv | 122 ++++++++++++
 tb/tb_alu_rr_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sched.sv
// alu_rr_sched
//   Shares one 4-bit ALU among NREQ requesters. A round-robin arbiter picks
//   one pending requester per cycle. Its operands go through the ALU
//   combinationally. The result lands in a single-entry output register,
//   tagged with the index of the winning requester.
//
// Ports
//   clk, rst    clock and synchronous active-high reset
//   req_valid   per-requester request valid               [NREQ]
//   req_a/req_b per-requester 4-bit operands, packed       [4*NREQ]
//   req_op      per-requester 2-bit opcode, packed         [2*NREQ]
//   req_ready   one-hot grant; handshake = valid & ready   [NREQ]
//   res_valid   output register holds a result
//   res_ready   consumer accepts the result
//   res_id      index of the requester that produced the result
//   res_out     5-bit ALU result
//   done_count  results consumed since reset, wraps        [CNTW]
module alu_rr_sched #(
   parameter int NREQ = 6,
   parameter int IDW  = $clog2(NREQ),
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   input  logic [2*NREQ-1:0] req_op,
   output logic [NREQ-1:0]   req_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [IDW-1:0]    res_id,
   output logic [4:0]        res_out,
   output logic [CNTW-1:0]   done_count
);

   // One extra bit so that ptr + k (at most 2*NREQ-2) cannot overflow
   // before the modulo wrap.
   localparam int             SW   = IDW + 1;
   localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);
   localparam logic [IDW-1:0] ONE  = IDW'(1);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_next;
   logic [IDW-1:0] win;
   logic [IDW-1:0] cand;
   logic [SW-1:0]  sum;
   logic           found;
   logic           accept;
   logic           grant;
   logic [3:0]     sel_a;
   logic [3:0]     sel_b;
   logic [1:0]     sel_op;
   logic [4:0]     alu_res;

   function automatic logic [4:0] alu(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic [1:0] op);
      logic [4:0] r;
      unique case (op)
         2'd0:    r = {1'b0, a} + {1'b0, b};
         2'd1:    r = {1'b0, a} - {1'b0, b};
         2'd2:    r = {1'b0, a & b};
         default: r = {1'b0, a | b};
      endcase
      return r;
   endfunction

   // Round-robin scan starting at ptr. The first valid index wins.
   always_comb begin
      // NOTE: every variable gets a default before the loop, so no path
      // leaves one unassigned and no latch is inferred.
      found = 1'b0;
      win   = '0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + SW'(k);
         if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
         cand = sum[IDW-1:0];
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign sel_a    = req_a[{win, 2'b00} +: 4];
   assign sel_b    = req_b[{win, 2'b00} +: 4];
   assign sel_op   = req_op[{win, 1'b0} +: 2];
   assign alu_res  = alu(sel_a, sel_b, sel_op);
   assign ptr_next = (win == LAST) ? '0 : win + ONE;

   // The output register can take a new result when it is empty or is
   // being drained this cycle. No grant is issued while reset is asserted.
   assign accept    = !res_valid || res_ready;
   assign grant     = accept && found && !rst;
   assign req_ready = grant ? (NREQ'(1) << win) : '0;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments, so every register samples
      // pre-edge values regardless of statement order.
      if (rst) begin
         res_valid  <= 1'b0;
         res_id     <= '0;
         res_out    <= '0;
         ptr        <= '0;
         done_count <= '0;
      end else begin
         if (res_valid && res_ready) done_count <= done_count + CNTW'(1);
         if (accept) begin
            res_valid <= found;
            if (found) begin
               res_id  <= win;
               res_out <= alu_res;
               ptr     <= ptr_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched
//   Scoreboard bench for alu_rr_sched. The driver predicts the winner of
//   each cycle and checks req_ready against it. For each grant it pushes
//   the expected {id, result} onto a queue. A negedge monitor pops an
//   entry on every consumed result and compares it with the DUT output.
//   The monitor also tracks done_count.
module tb_alu_rr_sched;

   localparam int NREQ = 6;
   localparam int IDW  = 3;
   localparam int CNTW = 16;

   typedef struct {
      logic [IDW-1:0] id;
      logic [4:0]     out;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic [2*NREQ-1:0] req_op;
   logic [NREQ-1:0]   req_ready;
   logic              res_valid;
   logic              res_ready;
   logic [IDW-1:0]    res_id;
   logic [4:0]        res_out;
   logic [CNTW-1:0]   done_count;

   logic [3:0] a_arr  [NREQ];
   logic [3:0] b_arr  [NREQ];
   logic [1:0] op_arr [NREQ];

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   exp_done = 0;
   bit   mon_en   = 1'b0;

   alu_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .req_ready  (req_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_id     (res_id),
      .res_out    (res_out),
      .done_count (done_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] op);
      int r;
      case (op)
         2'd0:    r = int'(a) + int'(b);
         2'd1:    r = (int'(a) + 32 - int'(b)) % 32;
         2'd2:    r = int'(a & b);
         default: r = int'(a | b);
      endcase
      return r[4:0];
   endfunction

   task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op);
      a_arr[i]  = a;
      b_arr[i]  = b;
      op_arr[i] = op;
   endtask

   task automatic pack_ops();
      for (int i = 0; i < NREQ; i++) begin
         req_a[4*i +: 4]  = a_arr[i];
         req_b[4*i +: 4]  = b_arr[i];
         req_op[2*i +: 2] = op_arr[i];
      end
   endtask

   // One clock of stimulus. exp_w < 0 means no grant is expected.
   task automatic cycle(input logic [NREQ-1:0] v, input int exp_w, input logic rr);
      logic [NREQ-1:0] exp_rdy;
      exp_t            e;
      req_valid = v;
      res_ready = rr;
      pack_ops();
      #1;
      exp_rdy = '0;
      if (exp_w >= 0) exp_rdy[exp_w] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_w >= 0) begin
         e.id  = exp_w[IDW-1:0];
         e.out = alu_model(a_arr[exp_w], b_arr[exp_w], op_arr[exp_w]);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [NREQ-1:0] v);
      rst       = 1'b1;
      req_valid = v;
      res_ready = 1'b0;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      sb.delete();
      exp_done = 0;
      check("rst_res_valid", 32'(res_valid), 32'h0);
      check("rst_done_count", 32'(done_count), 32'h0);
      check("rst_res_id", 32'(res_id), 32'h0);
      check("rst_res_out", 32'(res_out), 32'h0);
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && !rst) begin
         check("done_count", 32'(done_count), 32'(exp_done[CNTW-1:0]));
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'(res_id), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("res_id", 32'(res_id), 32'(e.id));
               check("res_out", 32'(res_out), 32'(e.out));
            end
            exp_done++;
         end
      end
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      res_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 1), 4'(15 - i), 2'(i));
      pack_ops();
      @(posedge clk);
      #1;
      do_reset('0);
      mon_en = 1'b1;

      // 1: single request from req 2, then ptr must sit at 3
      set_req(2, 4'h9, 4'h8, 2'd0);
      cycle(6'b000100, 2, 1'b1);
      check("t1_res_out", 32'(res_out), 32'h11);
      check("t1_res_id", 32'(res_id), 32'd2);
      cycle(6'b001001, 3, 1'b1);
      cycle(6'b000000, -1, 1'b1);

      // 2: all valid, fairness from ptr 0
      do_reset('0);
      for (int i = 0; i < NREQ; i++) set_req(i, 4'(3*i + 2), 4'(i + 7), 2'(i));
      for (int g = 0; g < 7; g++) cycle(6'b111111, g % NREQ, 1'b1);
      cycle(6'b000000, -1, 1'b1);
      check("t2_done7", 32'(done_count), 32'd7);
      check("t2_idle_valid", 32'(res_valid), 32'd0);

      // 3: subtract, and, or
      set_req(1, 4'h3, 4'h5, 2'd1);
      cycle(6'b000010, 1, 1'b1);
      check("t3_sub", 32'(res_out), 32'h1E);
      set_req(4, 4'hC, 4'hA, 2'd2);
      cycle(6'b010000, 4, 1'b1);
      check("t3_and", 32'(res_out), 32'h08);
      set_req(4, 4'hC, 4'hA, 2'd3);
      cycle(6'b010000, 4, 1'b1);
      check("t3_or", 32'(res_out), 32'h0E);
      cycle(6'b000000, -1, 1'b1);

      // 4: backpressure with req 0 and req 5 pending (ptr is 5)
      set_req(0, 4'h7, 4'h9, 2'd0);
      set_req(5, 4'h2, 4'h6, 2'd1);
      cycle(6'b100001, 5, 1'b0);
      for (int s = 0; s < 3; s++) begin
         cycle(6'b100001, -1, 1'b0);
         check("t4_hold_valid", 32'(res_valid), 32'd1);
         check("t4_hold_id", 32'(res_id), 32'd5);
         check("t4_hold_out", 32'(res_out), 32'h1C);
      end
      cycle(6'b100001, 0, 1'b1);
      cycle(6'b000000, -1, 1'b1);

      // 5: reset while a result is held and requests pend
      set_req(2, 4'hF, 4'h1, 2'd0);
      set_req(4, 4'h5, 4'h5, 2'd1);
      cycle(6'b010100, 2, 1'b0);
      do_reset(6'b010100);
      cycle(6'b010100, 2, 1'b1);
      cycle(6'b010000, 4, 1'b1);
      cycle(6'b000000, -1, 1'b1);

      // 6: sparse requests from req 3 (ptr is 5)
      set_req(3, 4'hA, 4'h6, 2'd0);
      cycle(6'b001000, 3, 1'b1);
      cycle(6'b000000, -1, 1'b1);
      check("t6_idle_valid", 32'(res_valid), 32'd0);
      cycle(6'b001000, 3, 1'b1);
      cycle(6'b000000, -1, 1'b1);
      cycle(6'b000000, -1, 1'b1);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
